// File: rtl/digital_clock_pkg.sv
// Shared constants and types for the BCD time-of-day counter.
package digital_clock_pkg;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Next packed-BCD value; wraps to zero after the terminal value.
  function automatic bcd2_t bcd2_next(input bcd2_t cur, input logic [7:0] max);
    bcd2_t nxt;
    nxt = cur;
    if (cur == bcd2_t'(max)) begin
      nxt = '0;
    end else if (cur.ones == 4'd9) begin
      nxt.ones = 4'd0;
      nxt.tens = cur.tens + 4'd1;
    end else begin
      nxt.ones = cur.ones + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit packed-BCD counter with a terminal value; carry is combinational so
// a chain of these updates every field on the same edge.
module bcd2_counter
  import digital_clock_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       inc_en,
  output logic [7:0] value,
  output logic       carry_out
);

  bcd2_t value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc_en) begin
      value_d = bcd2_next(value_q, MAX);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value     = value_q;
  assign carry_out = inc_en && (value_q == bcd2_t'(MAX));

endmodule

// File: rtl/digital_clock.sv
// 24-hour BCD time-of-day counter: prescaler drives a seconds/minutes/hours
// chain of two-digit BCD counters.
module digital_clock
  import digital_clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [7:0] sec,
  output logic [7:0] minute,
  output logic [7:0] hour
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          sec_carry, min_carry, hour_carry;

  // With one tick per second the prescaler sits at zero and tick is always set.
  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  bcd2_counter #(
    .MAX(SEC_MAX)
  ) u_sec (
    .clk      (clk),
    .resetn   (resetn),
    .inc_en   (tick),
    .value    (sec),
    .carry_out(sec_carry)
  );

  bcd2_counter #(
    .MAX(MIN_MAX)
  ) u_min (
    .clk      (clk),
    .resetn   (resetn),
    .inc_en   (sec_carry),
    .value    (minute),
    .carry_out(min_carry)
  );

  bcd2_counter #(
    .MAX(HOUR_MAX)
  ) u_hour (
    .clk      (clk),
    .resetn   (resetn),
    .inc_en   (min_carry),
    .value    (hour),
    .carry_out(hour_carry)
  );

  // The day wrap needs no downstream consumer.
  logic unused_hour_carry;
  assign unused_hour_carry = hour_carry;

endmodule

// File: tb/tb_digital_clock.sv
// Scoreboard bench for digital_clock: stimulus queues expected times keyed by
// edge count, monitors compare them on the falling clock edge.
module tb_digital_clock;

  typedef struct {
    int         at;
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    string      name;
  } exp_t;

  logic       clk;
  logic       resetn, resetn4;
  logic [7:0] sec, minute, hour;
  logic [7:0] sec4, minute4, hour4;

  int   n_checks = 0;
  int   n_errors = 0;
  int   edges, edges4;
  int   model_bad = 0;
  int   model_cycles = 0;
  bit   done1 = 0, done4 = 0;
  exp_t q1[$];
  exp_t q4[$];
  event sample_now;

  digital_clock dut (
    .clk   (clk),
    .resetn(resetn),
    .sec   (sec),
    .minute(minute),
    .hour  (hour)
  );

  digital_clock #(
    .TICKS_PER_SEC(4)
  ) dut4 (
    .clk   (clk),
    .resetn(resetn4),
    .sec   (sec4),
    .minute(minute4),
    .hour  (hour4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) edges <= 0;
    else         edges <= edges + 1;
  end

  always @(posedge clk or negedge resetn4) begin
    if (!resetn4) edges4 <= 0;
    else          edges4 <= edges4 + 1;
  end

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h (hh mm ss)", name, act, req);
    end
  endtask

  task automatic push1(input int at, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s, input string name);
    exp_t e;
    e.at = at; e.h = h; e.m = m; e.s = s; e.name = name;
    q1.push_back(e);
  endtask

  task automatic push4(input int at, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s, input string name);
    exp_t e;
    e.at = at; e.h = h; e.m = m; e.s = s; e.name = name;
    q4.push_back(e);
  endtask

  // Main monitor: scoreboard drain plus an independent arithmetic time model.
  initial begin
    exp_t        e;
    int          t;
    logic [23:0] ref_t;
    forever begin
      @(negedge clk or sample_now);
      if (resetn === 1'b1) begin
        t     = edges % 86400;
        ref_t = {to_bcd(t / 3600), to_bcd((t / 60) % 60), to_bcd(t % 60)};
        model_cycles++;
        if ({hour, minute, sec} !== ref_t) model_bad++;
      end
      while (q1.size() > 0 && q1[0].at <= edges) begin
        e = q1.pop_front();
        if (e.at < edges) check({e.name, "_missed"}, 24'(edges), 24'(e.at));
        else              check(e.name, {hour, minute, sec}, {e.h, e.m, e.s});
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q4.size() > 0 && q4[0].at <= edges4) begin
        e = q4.pop_front();
        if (e.at < edges4) check({e.name, "_missed"}, 24'(edges4), 24'(e.at));
        else               check(e.name, {hour4, minute4, sec4}, {e.h, e.m, e.s});
      end
    end
  end

  task automatic wait_edges(input int n);
    for (int i = 0; i < 200000 && edges < n; i++) @(negedge clk);
    if (edges < n) check("timeout_main", 24'(edges), 24'(n));
  endtask

  // Main stimulus (one tick per clock).
  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push1(0, 8'h00, 8'h00, 8'h00, "reset_hold");
      @(negedge clk);
    end
    #1 resetn = 1'b1;
    push1(1,    8'h00, 8'h00, 8'h01, "first_edge");
    push1(10,   8'h00, 8'h00, 8'h10, "sec_digit_roll");
    push1(59,   8'h00, 8'h00, 8'h59, "sec_max");
    push1(60,   8'h00, 8'h01, 8'h00, "min_carry");
    push1(3599, 8'h00, 8'h59, 8'h59, "pre_hour");
    push1(3600, 8'h01, 8'h00, 8'h00, "hour_carry");
    push1(5000, 8'h01, 8'h23, 8'h20, "pre_async_rst");
    wait_edges(5000);
    // Pulse reset between edges and sample before the next rising edge.
    #1 resetn = 1'b0;
    push1(0, 8'h00, 8'h00, 8'h00, "async_rst");
    #1 -> sample_now;
    #1 resetn = 1'b1;
    push1(1,     8'h00, 8'h00, 8'h01, "restart");
    push1(36000, 8'h10, 8'h00, 8'h00, "hour_ten");
    push1(86399, 8'h23, 8'h59, 8'h59, "day_end");
    push1(86400, 8'h00, 8'h00, 8'h00, "day_wrap");
    push1(86401, 8'h00, 8'h00, 8'h01, "after_wrap");
    wait_edges(86401);
    #1 done1 = 1'b1;
  end

  // Prescaled instance: four clocks per second.
  initial begin
    resetn4 = 1'b0;
    repeat (2) @(negedge clk);
    #1 resetn4 = 1'b1;
    push4(3,   8'h00, 8'h00, 8'h00, "tps4_3");
    push4(4,   8'h00, 8'h00, 8'h01, "tps4_4");
    push4(8,   8'h00, 8'h00, 8'h02, "tps4_8");
    push4(239, 8'h00, 8'h00, 8'h59, "tps4_239");
    push4(240, 8'h00, 8'h01, 8'h00, "tps4_240");
    for (int i = 0; i < 1000 && edges4 < 240; i++) @(negedge clk);
    if (edges4 < 240) check("timeout_tps4", 24'(edges4), 24'd240);
    #1 done4 = 1'b1;
  end

  initial begin
    for (int i = 0; i < 300000 && !(done1 && done4); i++) @(posedge clk);
    if (!(done1 && done4)) check("timeout_global", {22'd0, done1, done4}, 24'h000003);
    check("q1_drained", 24'(q1.size()), 24'd0);
    check("q4_drained", 24'(q4.size()), 24'd0);
    check("model_sweep_bad_cycles", 24'(model_bad), 24'd0);
    if (model_cycles < 90000) check("model_sweep_cycles", 24'(model_cycles), 24'd90000);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
